keccak_sponge_ctrl: RTL

- Parametrised, memory-fed Keccak sponge controller; successor to the fixed SHA3-512 front end.
- Streams a message of run-time length from a single-port RAM and packs it into RATE-bit blocks.
- Applies mode-selected multi-rate padding (SHA3 / SHAKE / legacy Keccak) and hands blocks to an external f_permutation core.
- Squeezes a configurable number of output bits, issuing extra permutations when OUT_BITS > RATE.

---
 rtl/keccak_sponge_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/keccak_sponge_ctrl.sv
// Memory-fed Keccak sponge controller: packs RAM words into rate blocks, pads per mode,
// hands blocks to an external permutation core and squeezes OUT_BITS of digest.
module keccak_sponge_ctrl #(
  parameter int unsigned W        = 64,
  parameter int unsigned RATE     = 1088,
  parameter int unsigned OUT_BITS = 256,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned LEN_W    = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [1:0]          i_mode,
  input  logic [LEN_W-1:0]    i_len_words,
  output logic                o_mem_re,
  output logic [LEN_W-1:0]    o_mem_addr,
  input  logic [W-1:0]        i_mem_din,
  output logic [RATE-1:0]     o_blk_out,
  output logic                o_blk_valid,
  input  logic                i_blk_ack,
  input  logic                i_perm_done,
  input  logic [1599:0]       i_perm_state,
  output logic [OUT_BITS-1:0] o_digest,
  output logic                o_done,
  output logic                o_busy
);

  localparam int unsigned NW  = RATE / W;
  localparam int unsigned NSQ = (OUT_BITS + RATE - 1) / RATE;
  localparam int unsigned SW  = $clog2(NW + 1);
  localparam int unsigned QW  = $clog2(NSQ + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FILL    = 3'd1;
  localparam logic [2:0] S_PAD     = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_SQUEEZE = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]          r_state;
  logic [1:0]          r_mode;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W:0]      r_iss;
  logic [LEN_W:0]      r_land;
  logic [SW-1:0]       r_blk_iss;
  logic [SW-1:0]       r_slot;
  logic [RD_LAT-1:0]   r_vld;
  logic [RATE-1:0]     r_buf;
  logic [OUT_BITS-1:0] r_digest;
  logic [QW-1:0]       r_sq;
  logic                r_final;
  logic                r_pad_after;
  logic                r_mem_re;
  logic [LEN_W-1:0]    r_mem_addr;
  logic                r_blk_valid;
  logic                r_done;
  logic                r_busy;

  logic                w_issue;
  logic                w_land;
  logic                w_last;
  logic                w_full;
  logic [LEN_W:0]      w_land_nxt;
  logic [7:0]          w_dom;
  logic [RATE-1:0]     w_pad;
  logic [RATE-1:0]     w_fill;
  logic [OUT_BITS-1:0] w_dig_nxt;
  logic                w_unused_state;

  assign w_issue    = (r_state == S_FILL) && (r_iss < {1'b0, r_len}) && (r_blk_iss < SW'(NW));
  assign w_land     = r_vld[RD_LAT-1];
  assign w_land_nxt = r_land + 1'b1;
  assign w_last     = w_land && (w_land_nxt == {1'b0, r_len});
  assign w_full     = w_land && (r_slot == SW'(NW - 1));

  always_comb begin
    case (r_mode)
      2'b01:   w_dom = 8'h1F;
      2'b10:   w_dom = 8'h01;
      default: w_dom = 8'h06;
    endcase
  end

  // r_slot equals (len*W/8 mod RATE/8)/(W/8) at pad time, so the domain byte lands at slot*W.
  always_comb begin
    w_pad = '0;
    w_pad[RATE-1 -: 8] = 8'h80;
    w_pad = w_pad ^ (RATE'(w_dom) << (r_slot * W));
  end

  for (genvar s = 0; s < NW; s++) begin : g_slot
    assign w_fill[s*W +: W] = (r_slot == SW'(s)) ? i_mem_din : r_buf[s*W +: W];
  end

  for (genvar b = 0; b < OUT_BITS; b++) begin : g_dig
    assign w_dig_nxt[b] = (r_sq == QW'(b / RATE)) ? i_perm_state[b % RATE] : r_digest[b];
  end

  assign w_unused_state = ^i_perm_state[1599:RATE];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_mode      <= '0;
      r_len       <= '0;
      r_iss       <= '0;
      r_land      <= '0;
      r_blk_iss   <= '0;
      r_slot      <= '0;
      r_vld       <= '0;
      r_buf       <= '0;
      r_digest    <= '0;
      r_sq        <= '0;
      r_final     <= 1'b0;
      r_pad_after <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_addr  <= '0;
      r_blk_valid <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_mem_re <= 1'b0;
      r_vld[0] <= r_mem_re;
      for (int unsigned i = 1; i < RD_LAT; i++) r_vld[i] <= r_vld[i-1];

      if (w_issue) begin
        r_mem_re   <= 1'b1;
        r_mem_addr <= r_iss[LEN_W-1:0];
        r_iss      <= r_iss + 1'b1;
        r_blk_iss  <= r_blk_iss + 1'b1;
      end

      if (w_land) begin
        r_buf  <= w_fill;
        r_land <= w_land_nxt;
        r_slot <= w_full ? '0 : r_slot + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mode      <= i_mode;
            r_len       <= i_len_words;
            r_buf       <= '0;
            r_iss       <= '0;
            r_land      <= '0;
            r_slot      <= '0;
            r_blk_iss   <= '0;
            r_sq        <= '0;
            r_final     <= 1'b0;
            r_pad_after <= 1'b0;
            r_digest    <= '0;
            r_busy      <= 1'b1;
            r_state     <= (i_len_words == '0) ? S_PAD : S_FILL;
          end
        end
        S_FILL: begin
          if (w_last) begin
            if (w_full) begin
              r_pad_after <= 1'b1;
              r_blk_valid <= 1'b1;
              r_state     <= S_SEND;
            end else begin
              r_state <= S_PAD;
            end
          end else if (w_full) begin
            r_blk_valid <= 1'b1;
            r_state     <= S_SEND;
          end
        end
        S_PAD: begin
          r_buf       <= r_buf ^ w_pad;
          r_final     <= 1'b1;
          r_blk_valid <= 1'b1;
          r_state     <= S_SEND;
        end
        S_SEND: begin
          if (i_blk_ack) begin
            r_blk_valid <= 1'b0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_perm_done) begin
            if (r_final) begin
              r_digest <= w_dig_nxt;
              r_state  <= S_SQUEEZE;
            end else begin
              r_buf     <= '0;
              r_blk_iss <= '0;
              r_state   <= r_pad_after ? S_PAD : S_FILL;
            end
          end
        end
        S_SQUEEZE: begin
          if (r_sq < QW'(NSQ - 1)) begin
            r_sq        <= r_sq + 1'b1;
            r_buf       <= '0;
            r_blk_valid <= 1'b1;
            r_state     <= S_SEND;
          end else begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_re    = r_mem_re;
  assign o_mem_addr  = r_mem_addr;
  assign o_blk_out   = r_buf;
  assign o_blk_valid = r_blk_valid;
  assign o_digest    = r_digest;
  assign o_done      = r_done;
  assign o_busy      = r_busy;

endmodule
